inst_fetch_queue: RTL and testbench
===================================

// Module: inst_fetch_queue
// PURPOSE
//  Fetch-to-decode instruction buffer, consumer side of the PC/fetch stage. Accepts up to two
//  fetched instructions per cycle (pc, inst, fetch exception) and presents up to two to decode,
//  in order. Drives the back-pressure `stall` that freezes PC advance. Cleared by `flush`.
// PARAMETERS
//  DEPTH  8  entries; power of two, >= 4
//  PTR_W  3  log2(DEPTH); pointer width; count is PTR_W+1 bits
// PORTS
//  clk        in   1   clock, all state on posedge
//  rst        in   1   synchronous, active-high reset
//  flush      in   1   backend redirect; discard all contents
//  in_valid   in   2   slot valid; legal 00/01/11; 10 treated as 00
//  in_pc0     in   32  pc of slot 0 (older)
//  in_inst0   in   32  instruction word, slot 0
//  in_excp0   in   1   fetch exception flag, slot 0
//  in_cause0  in   7   exception cause, slot 0
//  in_pc1/in_inst1/in_excp1/in_cause1  in  32/32/1/7  same for slot 1 (younger)
//  deq_num    in   2   number of entries decode consumes this cycle (0..2)
//  stall      out  1   queue cannot take a pair; fetch must hold pc
//  out_valid  out  2   [0]: count>=1, [1]: count>=2
//  out_pc0/out_inst0/out_excp0/out_cause0  out  32/32/1/7  head entry
//  out_pc1/out_inst1/out_excp1/out_cause1  out  32/32/1/7  head+1 entry
// BEHAVIOUR
//  - State: array[DEPTH] of {pc,inst,excp,cause}; head, tail (PTR_W, wrap mod DEPTH); count.
//  - Reset (rst=1 at posedge): head=tail=count=0. Outputs: out_valid=00, stall=0; data outputs
//    undefined while invalid (bench must not check them). Reset mid-stream drops all entries.
//  - stall = (count > DEPTH-2), combinational from registered count only.
//  - Write: wr_num = stall ? 0 : (in_valid==11 ? 2 : in_valid==01 ? 1 : 0). Slot 0 at tail,
//    slot 1 at tail+1; tail += wr_num. stall=1 drops the whole write (no partial accept).
//  - Read: show-ahead; out_* combinational from array[head], array[head+1]. rd_num =
//    min(deq_num, count); deq_num 3 or > count is clamped, never underflows. head += rd_num.
//  - Same-cycle read and write both take effect: count_next = count + wr_num - rd_num. Write
//    admission uses pre-cycle count (not freed space), so count never exceeds DEPTH.
//  - Latency: entry written at edge N is on out_* after edge N, i.e. cycle N+1; no bypass.
//  - Order: strict FIFO; slot 0 precedes slot 1; exception fields pass through unmodified.
//  - Flush: priority over read/write; at edge head=tail=count=0, same-cycle write and deq
//    discarded; next cycle out_valid=00, stall=0. Flush with rst: reset result.
//  - Pointer wrap: head/tail overflow naturally at PTR_W bits; data contiguous across wrap.
// TESTING
//  1 rst high 1 cycle -> out_valid=00, stall=0; hold rst 3 cycles with in_valid=11 -> still empty.
//  2 empty, in_valid=11 pc 0x1c000000/0x1c000004, deq 0 -> next cycle out_valid=11,
//    out_pc0=0x1c000000, out_pc1=0x1c000004; stall=0.
//  3 DEPTH=8, 3 pair writes no deq -> count 6, stall=0; 4th pair -> count 8, stall=1; 5th
//    pair attempted -> dropped, count 8, head pc unchanged.
//  4 count 8 (stall=1), deq_num=2 + in_valid=11 same cycle -> write dropped, count 6, stall=0
//    next cycle, out_pc0 = third-oldest pc.
//  5 count 1 (pc 0x1c000010), in_valid=01 pc 0x1c000014, deq_num=3 -> rd clamped to 1;
//    next cycle out_valid=01, out_pc0=0x1c000014, in_excp0=1/cause carried to out_excp0/cause.
//  6 stream 20 pairs pc 0x1c000000+8k with deq_num=2 every cycle -> pcs emerge in order across
//    >=2 pointer wraps, count <= 2; then flush with in_valid=11 and deq 2 same cycle ->
//    out_valid=00 next cycle; next write pc 0x1c001000 appears as out_pc0.

Source files
------------

// File: rtl/inst_fetch_queue_if.sv
// Fetch/decode bundle for the instruction fetch queue.
// master = fetch+decode side, slave = the queue itself.
interface inst_fetch_queue_if;
    logic        flush;
    logic [1:0]  in_valid;
    logic [31:0] in_pc0;
    logic [31:0] in_inst0;
    logic        in_excp0;
    logic [6:0]  in_cause0;
    logic [31:0] in_pc1;
    logic [31:0] in_inst1;
    logic        in_excp1;
    logic [6:0]  in_cause1;
    logic [1:0]  deq_num;
    logic        stall;
    logic [1:0]  out_valid;
    logic [31:0] out_pc0;
    logic [31:0] out_inst0;
    logic        out_excp0;
    logic [6:0]  out_cause0;
    logic [31:0] out_pc1;
    logic [31:0] out_inst1;
    logic        out_excp1;
    logic [6:0]  out_cause1;

    modport master (
        output flush, in_valid, deq_num,
        output in_pc0, in_inst0, in_excp0, in_cause0,
        output in_pc1, in_inst1, in_excp1, in_cause1,
        input  stall, out_valid,
        input  out_pc0, out_inst0, out_excp0, out_cause0,
        input  out_pc1, out_inst1, out_excp1, out_cause1
    );

    modport slave (
        input  flush, in_valid, deq_num,
        input  in_pc0, in_inst0, in_excp0, in_cause0,
        input  in_pc1, in_inst1, in_excp1, in_cause1,
        output stall, out_valid,
        output out_pc0, out_inst0, out_excp0, out_cause0,
        output out_pc1, out_inst1, out_excp1, out_cause1
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// Fetch-to-decode instruction buffer: 2-wide in, 2-wide show-ahead out.
// Back-pressure via stall; flush empties the queue.
module inst_fetch_queue #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input logic               clk,
    input logic               rst,
    inst_fetch_queue_if.slave bus
);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        excp;
        logic [6:0]  cause;
    } entry_t;

    localparam logic [PTR_W:0] LP_STALL_TH = (PTR_W+1)'(DEPTH - 2);

    entry_t           r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;

    logic             w_stall;
    logic [1:0]       w_wr_num;
    logic [1:0]       w_deq_lim;
    logic [1:0]       w_rd_num;
    logic [PTR_W-1:0] w_tail1;
    logic [PTR_W-1:0] w_head1;
    logic             w_clr;
    entry_t           w_in0;
    entry_t           w_in1;
    entry_t           w_out0;
    entry_t           w_out1;

    // Admission looks only at the pre-cycle count, so a pair always fits.
    assign w_stall = (r_count > LP_STALL_TH);
    assign w_clr   = rst | bus.flush;

    always_comb begin
        w_wr_num = 2'd0;
        if (!w_stall) begin
            unique case (bus.in_valid)
                2'b11:   w_wr_num = 2'd2;
                2'b01:   w_wr_num = 2'd1;
                default: w_wr_num = 2'd0;
            endcase
        end
    end

    assign w_deq_lim = (bus.deq_num == 2'd3) ? 2'd2 : bus.deq_num;

    always_comb begin
        w_rd_num = w_deq_lim;
        if (r_count < {{(PTR_W-1){1'b0}}, w_deq_lim})
            w_rd_num = r_count[1:0];
    end

    assign w_tail1 = r_tail + PTR_W'(1);
    assign w_head1 = r_head + PTR_W'(1);

    assign w_in0 = '{pc: bus.in_pc0, inst: bus.in_inst0,
                     excp: bus.in_excp0, cause: bus.in_cause0};
    assign w_in1 = '{pc: bus.in_pc1, inst: bus.in_inst1,
                     excp: bus.in_excp1, cause: bus.in_cause1};

    always_ff @(posedge clk) begin
        if (w_clr) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_rd_num);
            r_tail  <= r_tail + PTR_W'(w_wr_num);
            r_count <= r_count + (PTR_W+1)'(w_wr_num)
                               - (PTR_W+1)'(w_rd_num);
        end
    end

    // Storage is not reset; validity comes from count alone.
    always_ff @(posedge clk) begin
        if (!w_clr) begin
            if (w_wr_num != 2'd0)
                r_mem[r_tail] <= w_in0;
            if (w_wr_num == 2'd2)
                r_mem[w_tail1] <= w_in1;
        end
    end

    assign w_out0 = r_mem[r_head];
    assign w_out1 = r_mem[w_head1];

    assign bus.stall      = w_stall;
    assign bus.out_valid  = {(r_count >= (PTR_W+1)'(2)),
                             (r_count != '0)};
    assign bus.out_pc0    = w_out0.pc;
    assign bus.out_inst0  = w_out0.inst;
    assign bus.out_excp0  = w_out0.excp;
    assign bus.out_cause0 = w_out0.cause;
    assign bus.out_pc1    = w_out1.pc;
    assign bus.out_inst1  = w_out1.inst;
    assign bus.out_excp1  = w_out1.excp;
    assign bus.out_cause1 = w_out1.cause;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: vector table for control outputs,
// FIFO scoreboard for the data presented to decode.
module tb_inst_fetch_queue;

    localparam int DEPTH = 8;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        excp;
        logic [6:0]  cause;
    } ent_t;

    typedef struct {
        logic        rst;
        logic        flush;
        logic [1:0]  valid;
        logic [1:0]  deq;
        logic [31:0] pc;
        logic        ex;
        logic [1:0]  ev;
        logic        es;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    ent_t expq[$];
    vec_t vec[22];

    inst_fetch_queue_if bus();

    inst_fetch_queue #(.DEPTH(DEPTH), .PTR_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic ent_t mk(input logic [31:0] pc, input logic ex);
        ent_t e;
        e.pc    = pc;
        e.inst  = pc ^ 32'hA5A5_0F0F;
        e.excp  = ex;
        e.cause = ex ? pc[8:2] : 7'd0;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic check_model();
        int n;
        n = expq.size();
        chk("out_valid", 32'(bus.out_valid), {30'd0, n >= 2, n >= 1});
        chk("stall", 32'(bus.stall), 32'(n > DEPTH - 2));
        if (n >= 1) begin
            chk("out_pc0", bus.out_pc0, expq[0].pc);
            chk("out_inst0", bus.out_inst0, expq[0].inst);
            chk("out_excp0", 32'({bus.out_excp0, bus.out_cause0}),
                32'({expq[0].excp, expq[0].cause}));
        end
        if (n >= 2) begin
            chk("out_pc1", bus.out_pc1, expq[1].pc);
            chk("out_inst1", bus.out_inst1, expq[1].inst);
            chk("out_excp1", 32'({bus.out_excp1, bus.out_cause1}),
                32'({expq[1].excp, expq[1].cause}));
        end
    endtask

    task automatic step(input logic r, input logic f, input logic [1:0] v,
                        input logic [1:0] d, input logic [31:0] pc,
                        input logic ex);
        ent_t e0;
        ent_t e1;
        int   n;
        int   rd;
        bit   st;
        e0 = mk(pc, ex);
        e1 = mk(pc + 32'd4, 1'b0);
        rst           = r;
        bus.flush     = f;
        bus.in_valid  = v;
        bus.deq_num   = d;
        bus.in_pc0    = e0.pc;
        bus.in_inst0  = e0.inst;
        bus.in_excp0  = e0.excp;
        bus.in_cause0 = e0.cause;
        bus.in_pc1    = e1.pc;
        bus.in_inst1  = e1.inst;
        bus.in_excp1  = e1.excp;
        bus.in_cause1 = e1.cause;
        if (r || f) begin
            expq.delete();
        end else begin
            n  = expq.size();
            st = (n > DEPTH - 2);
            rd = (d == 2'd3) ? 2 : int'(d);
            if (rd > n) rd = n;
            repeat (rd) void'(expq.pop_front());
            if (!st && v == 2'b11) begin
                expq.push_back(e0);
                expq.push_back(e1);
            end else if (!st && v == 2'b01) begin
                expq.push_back(e0);
            end
        end
        @(posedge clk);
        #1;
        check_model();
    endtask

    initial begin
        bus.flush = 1'b0; bus.in_valid = 2'b00; bus.deq_num = 2'd0;
        bus.in_pc0 = '0; bus.in_inst0 = '0; bus.in_excp0 = 1'b0;
        bus.in_cause0 = '0; bus.in_pc1 = '0; bus.in_inst1 = '0;
        bus.in_excp1 = 1'b0; bus.in_cause1 = '0;

        //           rst  fl  valid  deq  pc            ex  ev     es
        vec[0]  = '{1'b1, 1'b0, 2'b00, 2'd0, 32'h1c00_0000, 1'b0, 2'b00, 1'b0};
        vec[1]  = '{1'b1, 1'b0, 2'b11, 2'd0, 32'h1c00_0000, 1'b0, 2'b00, 1'b0};
        vec[2]  = '{1'b1, 1'b0, 2'b11, 2'd0, 32'h1c00_0000, 1'b0, 2'b00, 1'b0};
        vec[3]  = '{1'b1, 1'b0, 2'b11, 2'd0, 32'h1c00_0000, 1'b0, 2'b00, 1'b0};
        vec[4]  = '{1'b0, 1'b0, 2'b11, 2'd0, 32'h1c00_0000, 1'b0, 2'b11, 1'b0};
        vec[5]  = '{1'b0, 1'b0, 2'b00, 2'd2, 32'h0000_0000, 1'b0, 2'b00, 1'b0};
        vec[6]  = '{1'b0, 1'b0, 2'b11, 2'd0, 32'h1c00_0100, 1'b0, 2'b11, 1'b0};
        vec[7]  = '{1'b0, 1'b0, 2'b11, 2'd0, 32'h1c00_0108, 1'b1, 2'b11, 1'b0};
        vec[8]  = '{1'b0, 1'b0, 2'b11, 2'd0, 32'h1c00_0110, 1'b0, 2'b11, 1'b0};
        vec[9]  = '{1'b0, 1'b0, 2'b11, 2'd0, 32'h1c00_0118, 1'b0, 2'b11, 1'b1};
        vec[10] = '{1'b0, 1'b0, 2'b11, 2'd0, 32'h1c00_0900, 1'b0, 2'b11, 1'b1};
        vec[11] = '{1'b0, 1'b0, 2'b11, 2'd2, 32'h1c00_0a00, 1'b0, 2'b11, 1'b0};
        vec[12] = '{1'b0, 1'b0, 2'b00, 2'd2, 32'h0000_0000, 1'b0, 2'b11, 1'b0};
        vec[13] = '{1'b0, 1'b0, 2'b00, 2'd2, 32'h0000_0000, 1'b0, 2'b11, 1'b0};
        vec[14] = '{1'b0, 1'b0, 2'b00, 2'd2, 32'h0000_0000, 1'b0, 2'b00, 1'b0};
        vec[15] = '{1'b0, 1'b0, 2'b01, 2'd0, 32'h1c00_0010, 1'b0, 2'b01, 1'b0};
        vec[16] = '{1'b0, 1'b0, 2'b01, 2'd3, 32'h1c00_0014, 1'b1, 2'b01, 1'b0};
        vec[17] = '{1'b0, 1'b0, 2'b10, 2'd0, 32'h1c00_0020, 1'b0, 2'b01, 1'b0};
        vec[18] = '{1'b0, 1'b0, 2'b00, 2'd1, 32'h0000_0000, 1'b0, 2'b00, 1'b0};
        vec[19] = '{1'b0, 1'b0, 2'b11, 2'd0, 32'h1c00_0030, 1'b0, 2'b11, 1'b0};
        vec[20] = '{1'b0, 1'b1, 2'b11, 2'd2, 32'h1c00_0040, 1'b0, 2'b00, 1'b0};
        vec[21] = '{1'b1, 1'b1, 2'b11, 2'd0, 32'h1c00_0050, 1'b0, 2'b00, 1'b0};

        for (int i = 0; i < 22; i++) begin
            step(vec[i].rst, vec[i].flush, vec[i].valid, vec[i].deq,
                 vec[i].pc, vec[i].ex);
            chk($sformatf("tbl%0d_valid", i), 32'(bus.out_valid),
                32'(vec[i].ev));
            chk($sformatf("tbl%0d_stall", i), 32'(bus.stall),
                32'(vec[i].es));
        end

        // Head pc after the dropped 5th pair and after the stalled deq.
        step(1'b0, 1'b0, 2'b11, 2'd0, 32'h1c00_0200, 1'b0);
        step(1'b0, 1'b0, 2'b11, 2'd0, 32'h1c00_0208, 1'b0);
        step(1'b0, 1'b0, 2'b11, 2'd0, 32'h1c00_0210, 1'b0);
        step(1'b0, 1'b0, 2'b11, 2'd0, 32'h1c00_0218, 1'b0);
        step(1'b0, 1'b0, 2'b11, 2'd0, 32'h1c00_0fff, 1'b0);
        chk("full_head", bus.out_pc0, 32'h1c00_0200);
        step(1'b0, 1'b0, 2'b11, 2'd2, 32'h1c00_0eee, 1'b0);
        chk("third_oldest", bus.out_pc0, 32'h1c00_0208);
        chk("after_deq_stall", 32'(bus.stall), 32'd0);
        step(1'b0, 1'b1, 2'b00, 2'd0, 32'h0, 1'b0);

        // Streaming across several pointer wraps.
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b0, 2'b11, 2'd2, 32'h1c00_0000 + 32'(8 * k), 1'b0);
            chk("stream_pc0", bus.out_pc0, 32'h1c00_0000 + 32'(8 * k));
        end
        step(1'b0, 1'b1, 2'b11, 2'd2, 32'h1c00_0800, 1'b0);
        chk("flush_empty", 32'(bus.out_valid), 32'd0);
        step(1'b0, 1'b0, 2'b11, 2'd0, 32'h1c00_1000, 1'b0);
        chk("post_flush_pc", bus.out_pc0, 32'h1c00_1000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
